// File: rtl/mesi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mesi_cmd_decoder
// Purpose  : Front-end stage for the MESI line state machine. Accepts one
//            trace command at a time over valid/ready, optionally waits for a
//            snoop result from the shared bus model, and emits a one-cycle
//            3-bit MESI event code plus line address to the protocol FSM.
//            Also raises clear/print side requests and flags illegal codes.
// Ports    : clk, reset (async, active-high)
//            cmd_valid/cmd_ready/cmd_code/cmd_addr   - command handshake
//            snoop_valid/snoop_hit                   - snoop result
//            inbits/ev_valid/ev_addr/snoop_tmo       - event to protocol FSM
//            clear_req/print_req/err_cmd             - side-request pulses
//            read_cnt/write_cnt                      - statistics counters
// Config   : MESI_DEC_STATS_EN builds the statistics counters; when it is
//            undefined read_cnt/write_cnt are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module mesi_cmd_decoder #(
    parameter int ADDR_W        = 32,
    parameter int SNOOP_TIMEOUT = 15,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_code,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              snoop_valid,
    input  logic              snoop_hit,
    output logic [2:0]        inbits,
    output logic              ev_valid,
    output logic [ADDR_W-1:0] ev_addr,
    output logic              clear_req,
    output logic              print_req,
    output logic              err_cmd,
    output logic              snoop_tmo,
    output logic [CNT_W-1:0]  read_cnt,
    output logic [CNT_W-1:0]  write_cnt
);

    localparam int                c_tmo_w    = $clog2(SNOOP_TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(SNOOP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_SNOOP  = 2'd2,
        S_ISSUE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          code_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [c_tmo_w-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [2:0]          inbits_q, inbits_d;
    logic                ev_valid_q, ev_valid_d;
    logic [ADDR_W-1:0]   ev_addr_q, ev_addr_d;
    logic                clear_q, clear_d;
    logic                print_q, print_d;
    logic                err_q, err_d;
    logic                snoop_tmo_q, snoop_tmo_d;
    logic                w_xfer;
    logic                w_cnt_clr;
    logic                w_rd_inc;
    logic                w_wr_inc;

    assign cmd_ready = (state_q == S_IDLE);
    assign w_xfer    = cmd_valid && cmd_ready;

    // Event outputs are loaded on the edge that enters ISSUE, so ev_valid is
    // high for exactly the ISSUE cycle and inbits/ev_addr hold afterwards.
    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        inbits_d    = inbits_q;
        ev_addr_d   = ev_addr_q;
        ev_valid_d  = 1'b0;
        clear_d     = 1'b0;
        print_d     = 1'b0;
        err_d       = 1'b0;
        snoop_tmo_d = 1'b0;
        w_cnt_clr   = 1'b0;
        w_rd_inc    = 1'b0;
        w_wr_inc    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_xfer) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (code_q)
                    4'd0, 4'd2: begin
                        state_d   = S_SNOOP;
                        tmo_cnt_d = '0;
                    end
                    4'd1: begin
                        state_d    = S_ISSUE;
                        ev_valid_d = 1'b1;
                        inbits_d   = 3'b011;
                        ev_addr_d  = addr_q;
                    end
                    4'd3: begin
                        state_d    = S_ISSUE;
                        ev_valid_d = 1'b1;
                        inbits_d   = 3'b101;
                        ev_addr_d  = addr_q;
                    end
                    4'd4: begin
                        state_d    = S_ISSUE;
                        ev_valid_d = 1'b1;
                        inbits_d   = 3'b110;
                        ev_addr_d  = addr_q;
                    end
                    4'd8: begin
                        state_d   = S_IDLE;
                        clear_d   = 1'b1;
                        w_cnt_clr = 1'b1;
                    end
                    4'd9: begin
                        state_d = S_IDLE;
                        print_d = 1'b1;
                    end
                    default: begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                endcase
            end
            S_SNOOP: begin
                // A snoop result in the expiry cycle takes priority over the
                // timeout, so it is tested first.
                if (snoop_valid) begin
                    state_d    = S_ISSUE;
                    ev_valid_d = 1'b1;
                    inbits_d   = snoop_hit ? 3'b010 : 3'b001;
                    ev_addr_d  = addr_q;
                end else if (tmo_cnt_q == c_tmo_last) begin
                    state_d     = S_ISSUE;
                    ev_valid_d  = 1'b1;
                    inbits_d    = 3'b001;
                    ev_addr_d   = addr_q;
                    snoop_tmo_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + c_tmo_w'(1);
                end
            end
            S_ISSUE: begin
                state_d  = S_IDLE;
                w_rd_inc = (code_q == 4'd0) || (code_q == 4'd2);
                w_wr_inc = (code_q == 4'd1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            addr_q      <= '0;
            tmo_cnt_q   <= '0;
            inbits_q    <= 3'b000;
            ev_valid_q  <= 1'b0;
            ev_addr_q   <= '0;
            clear_q     <= 1'b0;
            print_q     <= 1'b0;
            err_q       <= 1'b0;
            snoop_tmo_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            inbits_q    <= inbits_d;
            ev_valid_q  <= ev_valid_d;
            ev_addr_q   <= ev_addr_d;
            clear_q     <= clear_d;
            print_q     <= print_d;
            err_q       <= err_d;
            snoop_tmo_q <= snoop_tmo_d;
            if (w_xfer) begin
                code_q <= cmd_code;
                addr_q <= cmd_addr;
            end
        end
    end

    assign inbits    = inbits_q;
    assign ev_valid  = ev_valid_q;
    assign ev_addr   = ev_addr_q;
    assign clear_req = clear_q;
    assign print_req = print_q;
    assign err_cmd   = err_q;
    assign snoop_tmo = snoop_tmo_q;

`ifdef MESI_DEC_STATS_EN
    logic [CNT_W-1:0] read_cnt_q;
    logic [CNT_W-1:0] write_cnt_q;

    // Saturating counters: hold at all-ones rather than wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_cnt_q  <= '0;
            write_cnt_q <= '0;
        end else if (w_cnt_clr) begin
            read_cnt_q  <= '0;
            write_cnt_q <= '0;
        end else begin
            if (w_rd_inc && !(&read_cnt_q))  read_cnt_q  <= read_cnt_q + CNT_W'(1);
            if (w_wr_inc && !(&write_cnt_q)) write_cnt_q <= write_cnt_q + CNT_W'(1);
        end
    end

    assign read_cnt  = read_cnt_q;
    assign write_cnt = write_cnt_q;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_cnt_clr ^ w_rd_inc ^ w_wr_inc;
    assign read_cnt       = '0;
    assign write_cnt      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mesi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesi_cmd_decoder
// Purpose  : Self-checking bench for mesi_cmd_decoder. Stimulus pushes the
//            expected response of each command into a queue; an independent
//            monitor pops and compares whenever the DUT emits an event or a
//            side-request pulse. Honors MESI_DEC_STATS_EN for the counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mesi_cmd_decoder;

    localparam int ADDR_W = 32;
    localparam int TMO    = 15;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [3:0]        cmd_code = 4'd0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic              snoop_valid = 1'b0;
    logic              snoop_hit = 1'b0;
    logic [2:0]        inbits;
    logic              ev_valid;
    logic [ADDR_W-1:0] ev_addr;
    logic              clear_req, print_req, err_cmd, snoop_tmo;
    logic [CNT_W-1:0]  read_cnt, write_cnt;

    int errors = 0;
    int checks = 0;

    // kind: 0 = event, 1 = clear, 2 = print, 3 = error
    typedef struct {
        int          kind;
        logic [2:0]  inb;
        logic [31:0] addr;
        logic        tmo;
    } exp_t;

    exp_t        exp_q[$];
    int          m_rd = 0;
    int          m_wr = 0;
    logic [2:0]  last_inb = 3'b000;
    logic [31:0] last_addr = '0;

    mesi_cmd_decoder #(
        .ADDR_W(ADDR_W), .SNOOP_TIMEOUT(TMO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_addr(cmd_addr),
        .snoop_valid(snoop_valid), .snoop_hit(snoop_hit),
        .inbits(inbits), .ev_valid(ev_valid), .ev_addr(ev_addr),
        .clear_req(clear_req), .print_req(print_req), .err_cmd(err_cmd),
        .snoop_tmo(snoop_tmo), .read_cnt(read_cnt), .write_cnt(write_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference model: the response a command must produce, given the SNOOP
    // cycle index k at which the bus answers (k >= TMO means never).
    function automatic exp_t model(input logic [3:0] code, input logic [31:0] addr,
                                   input int k, input logic hit);
        exp_t e;
        e.kind = 0; e.inb = 3'b000; e.addr = addr; e.tmo = 1'b0;
        case (code)
            4'd0, 4'd2: begin
                if (k < TMO) e.inb = hit ? 3'b010 : 3'b001;
                else begin e.inb = 3'b001; e.tmo = 1'b1; end
            end
            4'd1:    e.inb = 3'b011;
            4'd3:    e.inb = 3'b101;
            4'd4:    e.inb = 3'b110;
            4'd8:    e.kind = 1;
            4'd9:    e.kind = 2;
            default: e.kind = 3;
        endcase
        return e;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    function automatic int exp_cnt(input int v);
`ifdef MESI_DEC_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic check_cnt();
        chk("read_cnt",  64'(read_cnt),  64'(exp_cnt(m_rd)));
        chk("write_cnt", 64'(write_cnt), 64'(exp_cnt(m_wr)));
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!cmd_ready) chk("ready_timeout", 64'(cmd_ready), 64'd1);
    endtask

    // Issues one command; always returns 1 time unit after a rising edge.
    task automatic do_cmd(input logic [3:0] code, input logic [31:0] addr,
                          input int k, input logic hit);
        exp_t e;
        wait_ready();
        check_cnt();
        e = model(code, addr, k, hit);
        exp_q.push_back(e);
        case (code)
            4'd0, 4'd2: m_rd = sat_inc(m_rd);
            4'd1:       m_wr = sat_inc(m_wr);
            4'd8:       begin m_rd = 0; m_wr = 0; end
            default:    ;
        endcase
        cmd_valid = 1'b1; cmd_code = code; cmd_addr = addr;
        @(posedge clk); #1;                       // DECODE cycle
        cmd_valid = 1'b0;
        cmd_code  = 4'($urandom);
        cmd_addr  = $urandom;
        chk("ready_decode", 64'(cmd_ready), 64'd0);
        snoop_valid = 1'b1;                        // must be ignored here
        snoop_hit   = 1'($urandom);
        @(posedge clk); #1;                       // SNOOP idx 0 / ISSUE / IDLE
        snoop_valid = 1'b0;
        if (code == 4'd0 || code == 4'd2) begin
            if (k < TMO) begin
                repeat (k) begin @(posedge clk); #1; end
                snoop_valid = 1'b1; snoop_hit = hit;
                @(posedge clk); #1;
                snoop_valid = 1'b0;
            end else begin
                repeat (TMO) begin @(posedge clk); #1; end
            end
            chk("snoop_latency", 64'(ev_valid), 64'd1);
        end else if (code == 4'd1 || code == 4'd3 || code == 4'd4) begin
            chk("issue_latency", 64'(ev_valid), 64'd1);
            chk("ready_issue", 64'(cmd_ready), 64'd0);
        end else begin
            chk("ready_side", 64'(cmd_ready), 64'd1);
            chk("no_ev_side", 64'(ev_valid), 64'd0);
        end
    endtask

    // Monitor: compares every DUT output pulse against the scoreboard.
    always @(negedge clk) begin : mon
        int   np;
        int   obs;
        exp_t e;
        if (reset) begin
            last_inb  = 3'b000;
            last_addr = '0;
        end else begin
            np  = int'(ev_valid) + int'(clear_req) + int'(print_req) + int'(err_cmd);
            obs = ev_valid ? 0 : clear_req ? 1 : print_req ? 2 : 3;
            if (np > 1) begin
                chk("one_pulse", 64'(np), 64'd1);
            end else if (np == 1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(obs), 64'hFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_kind", 64'(obs), 64'(e.kind));
                    if (e.kind == 0) begin
                        chk("inbits",    64'(inbits),    64'(e.inb));
                        chk("ev_addr",   64'(ev_addr),   64'(e.addr));
                        chk("snoop_tmo", 64'(snoop_tmo), 64'(e.tmo));
                        last_inb  = e.inb;
                        last_addr = e.addr;
                    end
                end
            end else begin
                chk("inbits_hold", 64'(inbits),  64'(last_inb));
                chk("addr_hold",   64'(ev_addr), 64'(last_addr));
            end
            if (!ev_valid) chk("tmo_without_ev", 64'(snoop_tmo), 64'd0);
        end
    end

    initial begin
        logic [3:0] code;
        int         r;
        // Power-on reset
        #1 reset = 1'b1;
        #2;
        chk("rst_ready",    64'(cmd_ready), 64'd1);
        chk("rst_ev_valid", 64'(ev_valid),  64'd0);
        chk("rst_inbits",   64'(inbits),    64'd0);
        chk("rst_ev_addr",  64'(ev_addr),   64'd0);
        chk("rst_pulses",   64'({clear_req, print_req, err_cmd, snoop_tmo}), 64'd0);
        check_cnt();
        @(posedge clk); #1 reset = 1'b0;

        // Write, then reset in the middle of a snooping read
        do_cmd(4'd1, 32'h0000_1040, 0, 1'b0);
        wait_ready();
        check_cnt();
        cmd_valid = 1'b1; cmd_code = 4'd0; cmd_addr = 32'hDEAD_0000;
        @(posedge clk); #1 cmd_valid = 1'b0;       // DECODE
        @(posedge clk); #1;                        // SNOOP idx 0
        @(posedge clk); #2 reset = 1'b1;           // SNOOP idx 1
        #1;
        m_rd = 0; m_wr = 0;
        chk("midrst_ready",  64'(cmd_ready), 64'd1);
        chk("midrst_ev",     64'(ev_valid),  64'd0);
        chk("midrst_inbits", 64'(inbits),    64'd0);
        check_cnt();
        @(posedge clk); #1;
        chk("midrst_ev_hold", 64'(ev_valid), 64'd0);
        reset = 1'b0;

        // Snooped reads, timeouts, other codes
        do_cmd(4'd0, 32'h0000_2000, 2, 1'b1);
        do_cmd(4'd0, 32'h0000_2040, 2, 1'b0);
        do_cmd(4'd2, 32'h0000_3000, TMO + 5, 1'b0);
        do_cmd(4'd2, 32'h0000_3040, TMO - 1, 1'b1);
        do_cmd(4'd2, 32'h0000_3080, 0, 1'b1);
        do_cmd(4'd3, 32'h0000_4000, 0, 1'b0);
        do_cmd(4'd4, 32'h0000_5000, 0, 1'b0);
        do_cmd(4'd9, 32'h0000_6000, 0, 1'b0);
        do_cmd(4'd7, 32'h0000_7000, 0, 1'b0);

        // Saturation then clear
        for (int i = 0; i < 5; i++) do_cmd(4'd1, 32'h0000_8000 + 32'(i * 64), 0, 1'b0);
        do_cmd(4'd8, 32'h0, 0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 19));
            if      (r < 5)   code = 4'd0;
            else if (r < 10)  code = 4'd1;
            else if (r < 12)  code = 4'd2;
            else if (r == 12) code = 4'd3;
            else if (r == 13) code = 4'd4;
            else if (r == 14) code = 4'd8;
            else if (r == 15) code = 4'd9;
            else              code = 4'($urandom_range(0, 15));
            do_cmd(code, $urandom, int'($urandom_range(0, TMO + 3)), 1'($urandom));
        end

        wait_ready();
        repeat (3) begin @(posedge clk); #1; end
        check_cnt();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mesi_cmd_decoder.md
Name: mesi_cmd_decoder

Overview:
- Front-end stage for the MESI line state machine. Accepts one trace command at a time over a valid/ready handshake.
- Gets a snoop result from the shared bus model when the command needs one.
- Emits a one-cycle 3-bit MESI event code (`inbits`) and the line address to the downstream protocol FSM.
- Also generates clear/print side requests and flags illegal commands.

Parameters:
- ADDR_W, 32, width of command/line address
- SNOOP_TIMEOUT, 15, cycles to wait for snoop_valid before treating the access as a miss (minimum 1)
- CNT_W, 16, width of statistics counters

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  decoder can accept a command
- cmd_code  input  4  trace command code
- cmd_addr  input  ADDR_W  command address
- snoop_valid  input  1  snoop result valid
- snoop_hit  input  1  another cache holds the line (sampled with snoop_valid)
- inbits  output  3  MESI event code to protocol FSM
- ev_valid  output  1  inbits/ev_addr valid, one-cycle pulse
- ev_addr  output  ADDR_W  line address of event
- clear_req  output  1  one-cycle pulse: reset all line states
- print_req  output  1  one-cycle pulse: dump contents
- err_cmd  output  1  one-cycle pulse: illegal cmd_code
- snoop_tmo  output  1  one-cycle pulse, coincident with ev_valid, when timeout forced a miss
- read_cnt  output  CNT_W  count of read/ifetch events issued
- write_cnt  output  CNT_W  count of write events issued

Behaviour:
- **Reset:** async on posedge reset.
  - State = IDLE.
  - All pulse outputs = 0; inbits = 3'b000; ev_addr = 0; counters = 0.
  - Timeout counter = 0; cmd_ready = 1.
- **Handshake:** transfer when cmd_valid && cmd_ready at posedge. cmd_ready = 1 only in IDLE. cmd_code/cmd_addr are latched at transfer; later input changes are ignored.
- **FSM states:** IDLE, DECODE, SNOOP, ISSUE.
  - IDLE: on transfer, go to DECODE.
  - DECODE: one cycle; classify the latched code.
    - Code 0 (data read), code 2 (ifetch): go to SNOOP, timeout counter cleared.
    - Code 1 (write): inbits_next = 3'b011, go to ISSUE.
    - Code 3 (invalidate from L2): inbits_next = 3'b101, go to ISSUE.
    - Code 4 (snooped read-for-ownership): inbits_next = 3'b110, go to ISSUE.
    - Code 8: clear_req pulse, counters cleared, go to IDLE.
    - Code 9: print_req pulse, go to IDLE.
    - Any other code: err_cmd pulse, go to IDLE. No event is issued.
  - SNOOP: wait for snoop_valid.
    - snoop_valid = 1: inbits_next = snoop_hit ? 3'b010 : 3'b001, go to ISSUE.
    - Timeout counter reaches SNOOP_TIMEOUT with no snoop_valid: inbits_next = 3'b001, set tmo flag, go to ISSUE.
    - snoop_valid in the same cycle the timeout expires: snoop result wins, no tmo.
    - snoop_valid outside SNOOP is ignored.
  - ISSUE: registered outputs for exactly one cycle.
    - ev_valid = 1, inbits = inbits_next, ev_addr = latched addr, snoop_tmo = tmo flag.
    - Next state is IDLE; tmo flag is cleared.
- **Outputs outside ISSUE:** ev_valid = 0. inbits and ev_addr hold their last issued value.
- **Latency (no snoop):** transfer at cycle N, ev_valid at N+2. Throughput is at most one command per 3 cycles.
- **Latency (snoop):** ev_valid 1 cycle after snoop_valid is sampled.
- **Counters:**
  - read_cnt increments in ISSUE for codes 0/2; write_cnt increments in ISSUE for code 1.
  - Counters saturate at all-ones; no wrap.
  - Code 8 clears both counters in DECODE.
- **Reset mid-operation:** any state returns to IDLE immediately. A pending command is dropped and no event is emitted.

Optional Feature:
- Macro: MESI_DEC_STATS_EN.
- **Defined:** read_cnt/write_cnt behave as above.
- **Undefined:** no counter registers are built; read_cnt and write_cnt are tied to 0. All other behaviour is unchanged.

Test Plan:
1. Reset asserted mid-SNOOP → next cycle state is IDLE, cmd_ready = 1, ev_valid stays 0, inbits = 3'b000, counters = 0.
2. Write, code 1, addr 0x0000_1040, accepted at cycle N → ev_valid = 1 at N+2 with inbits = 3'b011, ev_addr = 0x0000_1040; write_cnt = 1; cmd_ready = 0 at N+1 and N+2.
3. Read, code 0; snoop_valid = 1 with snoop_hit = 1 three cycles after DECODE → inbits = 3'b010, ev_valid one cycle later; repeat with snoop_hit = 0 → inbits = 3'b001; read_cnt = 2.
4. Ifetch, code 2, no snoop_valid → after SNOOP_TIMEOUT = 15 SNOOP cycles, ev_valid with inbits = 3'b001 and snoop_tmo = 1. Repeat with snoop_valid arriving exactly at the expiry cycle → snoop_tmo = 0.
5. Codes 3, 4 → inbits 3'b101 and 3'b110 respectively. Code 9 → print_req pulse, no ev_valid. Code 7 → err_cmd pulse, no ev_valid, cmd_ready back to 1 two cycles after transfer.
6. Counter test, with MESI_DEC_STATS_EN and CNT_W = 2: five writes → write_cnt saturates at 3. Then code 8 → clear_req pulse and write_cnt = 0. Without the macro, read_cnt and write_cnt read 0 throughout.
